// File: rtl/traffic_sensor_conditioner_pkg.sv
// Shared traffic-controller types: light/pedestrian encodings, debounce FSM states
// and the default debounce window.
package traffic_sensor_conditioner_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd8;
  localparam int unsigned DEBOUNCE_CNT_W          = 32'd8;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'd0,
    LIGHT_YELLOW = 2'd1,
    LIGHT_GREEN  = 2'd2
  } light_e;

  typedef enum logic [1:0] {
    PED_DONT_WALK = 2'd0,
    PED_WALK      = 2'd1,
    PED_FLASH     = 2'd2
  } ped_e;

  typedef enum logic [1:0] {
    DB_STABLE_LOW  = 2'd0,
    DB_CHECK_HIGH  = 2'd1,
    DB_STABLE_HIGH = 2'd2,
    DB_CHECK_LOW   = 2'd3
  } db_state_e;

  // The accepted level only changes once a CHECK state completes its window.
  function automatic logic db_level(input db_state_e s);
    return (s == DB_STABLE_HIGH) || (s == DB_CHECK_LOW);
  endfunction

endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// Sensor-side bundle: raw sensor inputs and ack from the light controller in,
// conditioned requests out.
interface traffic_sensor_conditioner_if;

  logic car_ns_raw;
  logic car_ew_raw;
  logic ped_raw;
  logic ped_ack;
  logic car_ns;
  logic car_ew;
  logic ped;

  modport master (
    output car_ns_raw, car_ew_raw, ped_raw, ped_ack,
    input  car_ns, car_ew, ped
  );

  modport slave (
    input  car_ns_raw, car_ew_raw, ped_raw, ped_ack,
    output car_ns, car_ew, ped
  );

endinterface

// File: rtl/traffic_sensor_conditioner_debounce_channel.sv
// One sensor channel: 2-flop synchronizer followed by a four-state debounce FSM
// that accepts a level only after DEBOUNCE_CYCLES consecutive matching samples.
module debounce_channel
  import traffic_sensor_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [DEBOUNCE_CNT_W-1:0] CNT_LAST = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic                      sync1_q;
  logic                      sync2_q;
  db_state_e                 state_q;
  db_state_e                 state_d;
  logic [DEBOUNCE_CNT_W-1:0] cnt_q;
  logic [DEBOUNCE_CNT_W-1:0] cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DB_STABLE_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A mismatching sample during a CHECK state abandons the window, so cnt never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DB_STABLE_LOW: begin
        if (sync2_q) begin
          state_d = DB_CHECK_HIGH;
          cnt_d   = DEBOUNCE_CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      DB_CHECK_HIGH: begin
        if (!sync2_q) begin
          state_d = DB_STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_STABLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + DEBOUNCE_CNT_W'(1);
        end
      end
      DB_STABLE_HIGH: begin
        if (!sync2_q) begin
          state_d = DB_CHECK_LOW;
          cnt_d   = DEBOUNCE_CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      DB_CHECK_LOW: begin
        if (sync2_q) begin
          state_d = DB_STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_STABLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + DEBOUNCE_CNT_W'(1);
        end
      end
      default: begin
        state_d = DB_STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o = db_level(state_q);
  // Leaving CHECK_LOW back to STABLE_HIGH is not a rise; only a 0->1 level change counts.
  assign rise_o  = !db_level(state_q) && db_level(state_d);

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the N/S, E/W and pedestrian sensors; define PED_LATCH_EN to hold a
// pedestrian request until the light controller acknowledges it.
module traffic_sensor_conditioner
  import traffic_sensor_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input logic                          clk,
  input logic                          rst,
  traffic_sensor_conditioner_if.slave  bus
);

  logic ns_level;
  logic ew_level;
  logic ped_level;
  logic ns_rise_unused;
  logic ew_rise_unused;
  logic ped_rise;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ns (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (bus.car_ns_raw),
    .level_o (ns_level),
    .rise_o  (ns_rise_unused)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ew (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (bus.car_ew_raw),
    .level_o (ew_level),
    .rise_o  (ew_rise_unused)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ped (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (bus.ped_raw),
    .level_o (ped_level),
    .rise_o  (ped_rise)
  );

  assign bus.car_ns = ns_level;
  assign bus.car_ew = ew_level;

`ifdef PED_LATCH_EN
  logic ped_latch_q;
  logic ped_latch_d;

  // A fresh press wins over a coincident ack so the new request is not lost.
  always_comb begin
    ped_latch_d = ped_latch_q;
    if (ped_rise) begin
      ped_latch_d = 1'b1;
    end else if (bus.ped_ack) begin
      ped_latch_d = 1'b0;
    end else begin
      ped_latch_d = ped_latch_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ped_latch_q <= 1'b0;
    end else begin
      ped_latch_q <= ped_latch_d;
    end
  end

  assign bus.ped = ped_latch_q;
`else
  logic ped_unused;
  assign ped_unused = ^{bus.ped_ack, ped_rise};
  assign bus.ped    = ped_level;
`endif

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Randomized bench with a run-length reference model of the debounce rule plus
// directed literal checks for latency, glitch rejection, ack priority and reset.
module tb_traffic_sensor_conditioner;

  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_sensor_conditioner_if bus();

  traffic_sensor_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: raw -> two-sample delay -> level flips after D consecutive disagreeing samples.
  bit m_s1  [3];
  bit m_s2  [3];
  int m_run [3];
  bit m_lvl [3];
  bit m_latch;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b expected=%b at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_ped();
`ifdef PED_LATCH_EN
    return m_latch;
`else
    return m_lvl[2];
`endif
  endfunction

  always @(posedge clk or negedge rst) begin : model
    int r;
    bit ped_rise;
    if (!rst) begin
      for (int c = 0; c < 3; c++) begin
        m_s1[c]  <= 1'b0;
        m_s2[c]  <= 1'b0;
        m_run[c] <= 0;
        m_lvl[c] <= 1'b0;
      end
      m_latch <= 1'b0;
    end else begin
      ped_rise = 1'b0;
      for (int c = 0; c < 3; c++) begin
        r = (m_s2[c] != m_lvl[c]) ? m_run[c] + 1 : 0;
        if (r == D) begin
          m_lvl[c] <= ~m_lvl[c];
          m_run[c] <= 0;
          if (c == 2 && !m_lvl[c]) ped_rise = 1'b1;
        end else begin
          m_run[c] <= r;
        end
        m_s2[c] <= m_s1[c];
      end
      m_s1[0] <= bus.car_ns_raw;
      m_s1[1] <= bus.car_ew_raw;
      m_s1[2] <= bus.ped_raw;
      if (ped_rise) m_latch <= 1'b1;
      else if (bus.ped_ack) m_latch <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("model_car_ns", bus.car_ns, m_lvl[0]);
    chk("model_car_ew", bus.car_ew, m_lvl[1]);
    chk("model_ped", bus.ped, exp_ped());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input int c, input logic v);
    case (c)
      0:       bus.car_ns_raw = v;
      1:       bus.car_ew_raw = v;
      default: bus.ped_raw    = v;
    endcase
  endtask

  initial begin
    int hold [3];
    bus.car_ns_raw = 1'b0;
    bus.car_ew_raw = 1'b0;
    bus.ped_raw    = 1'b0;
    bus.ped_ack    = 1'b0;
    #1 rst = 1'b0;
    repeat (3) step();
    chk("reset_car_ns", bus.car_ns, 1'b0);
    chk("reset_car_ew", bus.car_ew, 1'b0);
    chk("reset_ped", bus.ped, 1'b0);
    rst = 1'b1;

    // Pedestrian press: level rises exactly D+1 edges after the first sample.
    step();
    bus.ped_raw = 1'b1;
    repeat (D + 1) step();
    chk("ped_rise_not_early", bus.ped, 1'b0);
    step();
    chk("ped_rise_on_time", bus.ped, 1'b1);
    repeat (20 - D - 2) step();
    bus.ped_raw = 1'b0;
    repeat (2 * D + 2) step();
`ifdef PED_LATCH_EN
    chk("ped_held_until_ack", bus.ped, 1'b1);
`else
    chk("ped_follows_level", bus.ped, 1'b0);
`endif
    bus.ped_ack = 1'b1;
    step();
    bus.ped_ack = 1'b0;
    chk("ped_cleared_by_ack", bus.ped, 1'b0);

    // Short N/S glitch must never reach the output.
    bus.car_ns_raw = 1'b1;
    repeat (5) step();
    bus.car_ns_raw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("ns_glitch_rejected", bus.car_ns, 1'b0);
      chk("ew_unaffected", bus.car_ew, 1'b0);
    end

    // Ack coincident with a fresh debounced rise keeps the request set.
    bus.ped_raw = 1'b1;
    repeat (D + 2) step();
    chk("ped_second_press", bus.ped, 1'b1);
    bus.ped_raw = 1'b0;
    repeat (2 * D + 4) step();
    bus.ped_raw = 1'b1;
    repeat (D + 1) step();
    bus.ped_ack = 1'b1;
    step();
    bus.ped_ack = 1'b0;
    chk("ped_ack_vs_rise", bus.ped, 1'b1);
    step();
    chk("ped_ack_vs_rise_hold", bus.ped, 1'b1);
    bus.ped_raw = 1'b0;
    repeat (2 * D + 4) step();
    bus.ped_ack = 1'b1;
    step();
    bus.ped_ack = 1'b0;
    chk("ped_cleared_again", bus.ped, 1'b0);

    // Reset mid-window discards the partial count.
    bus.car_ew_raw = 1'b1;
    repeat (6) step();
    rst = 1'b0;
    #1;
    chk("midreset_car_ew", bus.car_ew, 1'b0);
    chk("midreset_ped", bus.ped, 1'b0);
    step();
    rst = 1'b1;
    repeat (D + 1) step();
    chk("ew_after_reset_not_early", bus.car_ew, 1'b0);
    step();
    chk("ew_after_reset_on_time", bus.car_ew, 1'b1);
    bus.car_ew_raw = 1'b0;
    repeat (2 * D) step();

    // Randomized traffic with mixed short and long holds, random acks and rare resets.
    for (int c = 0; c < 3; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < 3; c++) begin
        if (hold[c] == 0) begin
          set_raw(c, 1'($urandom_range(0, 1)));
          hold[c] = $urandom_range(1, 20);
        end else begin
          hold[c] = hold[c] - 1;
        end
      end
      bus.ped_ack = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b0;
        step();
        rst = 1'b1;
      end
      step();
    end
    bus.ped_ack = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
